// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Scans from a clock-enable tick, with frame-coherent shadow registers, PWM dimming and dead time.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SLOT_HZ    = 1000,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic                    i_hex_mode,
    input  logic                    i_lz_blank,
    input  logic [BRIGHT_W-1:0]     i_brightness,
    input  logic                    i_enable,
    output logic [NUM_DIGITS-1:0]   o_digit_anodes_n,
    output logic [7:0]              o_digit_cathode_n,
    output logic                    o_frame_done
);

    localparam int TICK_DIV = CLK_HZ / SLOT_HZ;
    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = $clog2(NUM_DIGITS);

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = {BRIGHT_W{1'b1}};

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [BRIGHT_W-1:0]     r_pwm;
    logic [4*NUM_DIGITS-1:0] r_sh_data;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic                    r_sh_hex;
    logic                    r_sh_lz;
    logic [BRIGHT_W-1:0]     r_sh_bright;
    logic [NUM_DIGITS-1:0]   r_anodes_n;
    logic [7:0]              r_cathode_n;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_wrap;
    logic [PRESC_W-1:0]      w_presc_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic [BRIGHT_W-1:0]     w_pwm_next;
    logic [4*NUM_DIGITS-1:0] w_data_next;
    logic [NUM_DIGITS-1:0]   w_dp_next;
    logic                    w_hex_next;
    logic                    w_lz_next;
    logic [BRIGHT_W-1:0]     w_bright_next;
    logic [3:0]              w_code;
    logic                    w_dp_bit;
    logic                    w_significant;
    logic                    w_seen;
    logic                    w_blank;
    logic                    w_pwm_on;
    logic                    w_lit;
    logic [7:0]              w_cathode_next;
    logic [NUM_DIGITS-1:0]   w_anodes_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Outputs are registered from next-state values so the cathode changes in the dead cycle itself.
    assign w_tick       = (r_presc == PRESC_LAST);
    assign w_wrap       = w_tick && (r_idx == IDX_LAST);
    assign w_presc_next = w_tick ? '0 : r_presc + PRESC_W'(1);
    assign w_idx_next   = w_wrap ? '0 : (w_tick ? r_idx + IDX_W'(1) : r_idx);
    assign w_pwm_next   = r_pwm + BRIGHT_W'(1);

    assign w_data_next   = w_wrap ? i_data       : r_sh_data;
    assign w_dp_next     = w_wrap ? i_dp         : r_sh_dp;
    assign w_hex_next    = w_wrap ? i_hex_mode   : r_sh_hex;
    assign w_lz_next     = w_wrap ? i_lz_blank   : r_sh_lz;
    assign w_bright_next = w_wrap ? i_brightness : r_sh_bright;

    // Walk from the most significant digit down; a digit is significant once any nonzero digit has been seen.
    always_comb begin
        w_code        = '0;
        w_dp_bit      = 1'b0;
        w_significant = 1'b0;
        w_seen        = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_seen = w_seen | (|w_data_next[4*k +: 4]);
            if (w_idx_next == IDX_W'(k)) begin
                w_code        = w_data_next[4*k +: 4];
                w_dp_bit      = w_dp_next[k];
                w_significant = w_seen | (k == 0);
            end
        end
    end

    assign w_blank        = (w_lz_next && !w_significant) || (!w_hex_next && (w_code > 4'd9));
    assign w_cathode_next = w_blank ? 8'hFF : {~w_dp_bit, seg_decode(w_code)};

    assign w_pwm_on = (w_bright_next == BRIGHT_MAX) || (w_pwm_next < w_bright_next);
    assign w_lit    = i_enable && !w_tick && w_pwm_on;

    always_comb begin
        w_anodes_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_anodes_next[k] = !(w_lit && (w_idx_next == IDX_W'(k)));
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pwm        <= '0;
            r_sh_data    <= '0;
            r_sh_dp      <= '0;
            r_sh_hex     <= 1'b0;
            r_sh_lz      <= 1'b0;
            r_sh_bright  <= '0;
            r_anodes_n   <= '1;
            r_cathode_n  <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_presc      <= w_presc_next;
            r_idx        <= w_idx_next;
            r_pwm        <= w_pwm_next;
            r_sh_data    <= w_data_next;
            r_sh_dp      <= w_dp_next;
            r_sh_hex     <= w_hex_next;
            r_sh_lz      <= w_lz_next;
            r_sh_bright  <= w_bright_next;
            r_anodes_n   <= w_anodes_next;
            r_cathode_n  <= w_cathode_next;
            r_frame_done <= w_wrap;
        end
    end

    assign o_digit_anodes_n  = r_anodes_n;
    assign o_digit_cathode_n = r_cathode_n;
    assign o_frame_done      = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: 4 digits, 10-cycle slots, 40-cycle frames.
// The reference model derives every output from the number of clock edges since reset.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int TDIV  = 10;
    localparam int FRAME = N * TDIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        hex;
    logic        lz;
    logic [3:0]  bright;
    logic        en;
    logic [3:0]  o_digit_anodes_n;
    logic [7:0]  o_digit_cathode_n;
    logic        o_frame_done;

    int          checks = 0;
    int          errors = 0;

    // Model state: edges since reset release and the inputs captured at the last frame wrap.
    int          nEdges;
    logic [15:0] mData;
    logic [3:0]  mDp;
    logic        mHex;
    logic        mLz;
    logic [3:0]  mBright;
    logic        mEnable;

    logic [3:0]  eA;
    logic [7:0]  eC;
    logic        eF;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .CLK_HZ(1000), .SLOT_HZ(100), .BRIGHT_W(4)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_dp(dp),
        .i_hex_mode(hex), .i_lz_blank(lz), .i_brightness(bright), .i_enable(en),
        .o_digit_anodes_n(o_digit_anodes_n), .o_digit_cathode_n(o_digit_cathode_n),
        .o_frame_done(o_frame_done)
    );

    function automatic logic [7:0] segOf(input logic [3:0] c);
        case (c)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic int curIdx();
        return (nEdges / TDIV) % N;
    endfunction

    function automatic logic [3:0] expAnodes();
        logic       on;
        logic [3:0] one;
        if (nEdges == 0) return 4'hF;
        one = 4'b0001;
        on  = mEnable && (nEdges % TDIV != 0) &&
              (mBright == 4'hF || (nEdges % 16) < int'(mBright));
        return on ? ~(one << curIdx()) : 4'hF;
    endfunction

    function automatic logic [7:0] expCathode();
        int         idx;
        int         top;
        logic [3:0] code;
        logic [7:0] s;
        if (nEdges == 0) return 8'hFF;
        idx = curIdx();
        top = -1;
        for (int j = N - 1; j >= 0; j--)
            if (top < 0 && mData[4*j +: 4] != 4'h0) top = j;
        code = mData[4*idx +: 4];
        if ((mLz && idx > top && idx != 0) || (!mHex && code > 4'd9)) return 8'hFF;
        s    = segOf(code);
        s[7] = ~mDp[idx];
        return s;
    endfunction

    function automatic logic expFrame();
        return (nEdges > 0) && (nEdges % FRAME == 0);
    endfunction

    task automatic resetModel();
        nEdges  = 0;
        mData   = '0;
        mDp     = '0;
        mHex    = 1'b0;
        mLz     = 1'b0;
        mBright = '0;
        mEnable = 1'b0;
    endtask

    // One clock: update the model at the rising edge, return at the falling edge for sampling.
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            nEdges++;
            mEnable = en;
            if (nEdges % FRAME == 0) begin
                mData = data; mDp = dp; mHex = hex; mLz = lz; mBright = bright;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data = 16'h0; dp = 4'h0; hex = 1'b0; lz = 1'b0; bright = 4'hF; en = 1'b1;
        resetModel();
        repeat (3) @(negedge clk);
        checks++;
        if (o_digit_anodes_n !== 4'hF || o_digit_cathode_n !== 8'hFF || o_frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold got an=%b cat=%h fd=%b want an=1111 cat=FF fd=0",
                     o_digit_anodes_n, o_digit_cathode_n, o_frame_done);
        end
        rst_n = 1'b1;
        checks++;
        if (o_digit_anodes_n !== 4'hF || o_digit_cathode_n !== 8'hFF || o_frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release got an=%b cat=%h fd=%b want an=1111 cat=FF fd=0",
                     o_digit_anodes_n, o_digit_cathode_n, o_frame_done);
        end
    endtask

    task automatic test_scan();
        logic [7:0] tCath [4];
        logic [3:0] tAn   [4];
        int         start;
        int         pulses;
        tCath = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        tAn   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        data = 16'h1234; dp = 4'h0; hex = 1'b0; lz = 1'b0; bright = 4'hF; en = 1'b1;
        start  = nEdges;
        pulses = 0;
        for (int c = 0; c < 120; c++) begin
            advance();
            eA = expAnodes(); eC = expCathode(); eF = expFrame();
            checks++;
            if (o_digit_anodes_n !== eA) begin errors++;
                $display("[TB] FAIL scan_anodes n=%0d got %b want %b", nEdges, o_digit_anodes_n, eA); end
            checks++;
            if (o_digit_cathode_n !== eC) begin errors++;
                $display("[TB] FAIL scan_cathode n=%0d got %h want %h", nEdges, o_digit_cathode_n, eC); end
            checks++;
            if (o_frame_done !== eF) begin errors++;
                $display("[TB] FAIL scan_frame n=%0d got %b want %b", nEdges, o_frame_done, eF); end
            if (o_frame_done) pulses++;
            if ((nEdges / FRAME) * FRAME > start && nEdges % TDIV != 0) begin
                checks++;
                if (o_digit_anodes_n !== tAn[curIdx()] || o_digit_cathode_n !== tCath[curIdx()]) begin
                    errors++;
                    $display("[TB] FAIL scan_1234 n=%0d got an=%b cat=%h want an=%b cat=%h", nEdges,
                             o_digit_anodes_n, o_digit_cathode_n, tAn[curIdx()], tCath[curIdx()]);
                end
            end
        end
        checks++;
        if (pulses != 3) begin errors++;
            $display("[TB] FAIL scan_pulse_count got %0d want 3", pulses); end
    endtask

    task automatic test_decode();
        logic [7:0] tA [4];
        logic [7:0] tB [4];
        int         start;
        tA = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
        tB = '{8'h92, 8'h88, 8'hFF, 8'hFF};
        for (int phase = 0; phase < 2; phase++) begin
            data = 16'h00A5; dp = 4'h0; lz = 1'b1; hex = (phase == 1); bright = 4'hF; en = 1'b1;
            start = nEdges;
            for (int c = 0; c < 100; c++) begin
                advance();
                eA = expAnodes(); eC = expCathode(); eF = expFrame();
                checks++;
                if (o_digit_anodes_n !== eA) begin errors++;
                    $display("[TB] FAIL decode_anodes n=%0d got %b want %b", nEdges, o_digit_anodes_n, eA); end
                checks++;
                if (o_digit_cathode_n !== eC) begin errors++;
                    $display("[TB] FAIL decode_cathode n=%0d got %h want %h", nEdges, o_digit_cathode_n, eC); end
                checks++;
                if (o_frame_done !== eF) begin errors++;
                    $display("[TB] FAIL decode_frame n=%0d got %b want %b", nEdges, o_frame_done, eF); end
                if ((nEdges / FRAME) * FRAME > start) begin
                    checks++;
                    eC = (phase == 1) ? tB[curIdx()] : tA[curIdx()];
                    if (o_digit_cathode_n !== eC) begin errors++;
                        $display("[TB] FAIL decode_00A5 hex=%0d n=%0d got %h want %h",
                                 phase, nEdges, o_digit_cathode_n, eC); end
                end
            end
        end
    endtask

    task automatic test_frame_coherence();
        data = 16'($urandom); dp = 4'($urandom); hex = 1'($urandom); lz = 1'($urandom);
        bright = 4'hF; en = 1'b1;
        for (int c = 0; c < 140; c++) begin
            advance();
            if (c >= 45 && nEdges % FRAME == 15) begin
                data = 16'($urandom); dp = ~dp; hex = ~hex;
            end
            eA = expAnodes(); eC = expCathode(); eF = expFrame();
            checks++;
            if (o_digit_anodes_n !== eA) begin errors++;
                $display("[TB] FAIL coherence_anodes n=%0d got %b want %b", nEdges, o_digit_anodes_n, eA); end
            checks++;
            if (o_digit_cathode_n !== eC) begin errors++;
                $display("[TB] FAIL coherence_cathode n=%0d got %h want %h", nEdges, o_digit_cathode_n, eC); end
            checks++;
            if (o_frame_done !== eF) begin errors++;
                $display("[TB] FAIL coherence_frame n=%0d got %b want %b", nEdges, o_frame_done, eF); end
        end
    endtask

    task automatic test_pwm();
        int start;
        for (int phase = 0; phase < 2; phase++) begin
            data = 16'h1234; dp = 4'h0; hex = 1'b0; lz = 1'b0; en = 1'b1;
            bright = (phase == 0) ? 4'd4 : 4'd0;
            start = nEdges;
            for (int c = 0; c < 120; c++) begin
                advance();
                eA = expAnodes(); eC = expCathode(); eF = expFrame();
                checks++;
                if (o_digit_anodes_n !== eA) begin errors++;
                    $display("[TB] FAIL pwm_anodes n=%0d got %b want %b", nEdges, o_digit_anodes_n, eA); end
                checks++;
                if (o_digit_cathode_n !== eC) begin errors++;
                    $display("[TB] FAIL pwm_cathode n=%0d got %h want %h", nEdges, o_digit_cathode_n, eC); end
                checks++;
                if (o_frame_done !== eF) begin errors++;
                    $display("[TB] FAIL pwm_frame n=%0d got %b want %b", nEdges, o_frame_done, eF); end
                if (nEdges % TDIV == 0 || (phase == 1 && (nEdges / FRAME) * FRAME > start)) begin
                    checks++;
                    if (o_digit_anodes_n !== 4'hF) begin errors++;
                        $display("[TB] FAIL pwm_dark n=%0d got %b want 1111", nEdges, o_digit_anodes_n); end
                end
            end
        end
    endtask

    task automatic test_reset_enable();
        int pulses;
        data = 16'h5678; dp = 4'h5; hex = 1'b0; lz = 1'b0; bright = 4'hF; en = 1'b1;
        for (int c = 0; c < 60 && !(c >= 45 && nEdges % TDIV == 5); c++) advance();
        checks++;
        if (o_digit_anodes_n === 4'hF) begin errors++;
            $display("[TB] FAIL pre_reset_lit n=%0d got %b want a lit anode", nEdges, o_digit_anodes_n); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_digit_anodes_n !== 4'hF || o_digit_cathode_n !== 8'hFF || o_frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got an=%b cat=%h fd=%b want an=1111 cat=FF fd=0",
                     o_digit_anodes_n, o_digit_cathode_n, o_frame_done);
        end
        resetModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 160; c++) begin
            if (c == 60) en = 1'b0;
            advance();
            eA = expAnodes(); eC = expCathode(); eF = expFrame();
            checks++;
            if (o_digit_anodes_n !== eA) begin errors++;
                $display("[TB] FAIL rst_en_anodes n=%0d got %b want %b", nEdges, o_digit_anodes_n, eA); end
            checks++;
            if (o_digit_cathode_n !== eC) begin errors++;
                $display("[TB] FAIL rst_en_cathode n=%0d got %h want %h", nEdges, o_digit_cathode_n, eC); end
            checks++;
            if (o_frame_done !== eF) begin errors++;
                $display("[TB] FAIL rst_en_frame n=%0d got %b want %b", nEdges, o_frame_done, eF); end
            if (c >= 60) begin
                if (o_frame_done) pulses++;
                checks++;
                if (o_digit_anodes_n !== 4'hF) begin errors++;
                    $display("[TB] FAIL disabled_dark n=%0d got %b want 1111", nEdges, o_digit_anodes_n); end
            end
            if (c < 9) begin
                checks++;
                if (o_digit_cathode_n !== 8'hC0) begin errors++;
                    $display("[TB] FAIL digit0_first n=%0d got %h want C0", nEdges, o_digit_cathode_n); end
            end
        end
        checks++;
        if (pulses < 2) begin errors++;
            $display("[TB] FAIL disabled_pulses got %0d want at least 2", pulses); end
        en = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) data = 16'($urandom);
            if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) hex = ~hex;
            if ($urandom_range(0, 15) == 0) lz = ~lz;
            if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 9) != 0);
            advance();
            eA = expAnodes(); eC = expCathode(); eF = expFrame();
            checks++;
            if (o_digit_anodes_n !== eA) begin errors++;
                $display("[TB] FAIL random_anodes n=%0d got %b want %b", nEdges, o_digit_anodes_n, eA); end
            checks++;
            if (o_digit_cathode_n !== eC) begin errors++;
                $display("[TB] FAIL random_cathode n=%0d got %h want %h", nEdges, o_digit_cathode_n, eC); end
            checks++;
            if (o_frame_done !== eF) begin errors++;
                $display("[TB] FAIL random_frame n=%0d got %b want %b", nEdges, o_frame_done, eF); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_frame_coherence();
        test_pwm();
        test_reset_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
